// File: rtl/onehot_run_encoder_if.sv
// rtl/onehot_run_encoder_if.sv - sample input and record output bundle for onehot_run_encoder
// drop_cnt is present only when DROP_COUNT_EN is defined.
interface onehot_run_encoder_if #(
  parameter int LEN_W = 8
);
  logic [7:0]       in_onehot;
  logic             flush;
  logic             rec_valid;
  logic             rec_ready;
  logic [2:0]       rec_idx;
  logic             rec_err;
  logic [LEN_W-1:0] rec_len;
  logic             fifo_full;
`ifdef DROP_COUNT_EN
  logic [7:0]       drop_cnt;
`endif

  modport slave (
    input  in_onehot, flush, rec_ready,
`ifdef DROP_COUNT_EN
    output drop_cnt,
`endif
    output rec_valid, rec_idx, rec_err, rec_len, fifo_full
  );

  modport master (
    output in_onehot, flush, rec_ready,
`ifdef DROP_COUNT_EN
    input  drop_cnt,
`endif
    input  rec_valid, rec_idx, rec_err, rec_len, fifo_full
  );
endinterface

// File: rtl/onehot_run_encoder.sv
// rtl/onehot_run_encoder.sv - run-length encoder of one-hot state words into a record FIFO
// Optional DROP_COUNT_EN adds a saturating dropped-record counter on drop_cnt.
module onehot_run_encoder #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_run_encoder_if.slave   bus
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int REC_W = 4 + LEN_W;
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cur_code, code_nxt;
  logic [LEN_W-1:0] run_len, len_nxt;
  logic [3:0]       samp_code;
  logic [3:0]       ones;
  logic [2:0]       pos;
  logic             push;
  logic [REC_W-1:0] push_rec;

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, pop, accept;
  logic [REC_W-1:0] head;

  // Code layout is {err, idx}; every illegal word collapses to 4'b1000.
  always_comb begin
    ones = 4'd0;
    pos  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.in_onehot[i]) begin
        ones = ones + 4'd1;
        pos  = 3'(i);
      end
    end
    samp_code = (ones == 4'd1) ? {1'b0, pos} : 4'b1000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_code <= 4'd0;
      run_len  <= '0;
    end else begin
      state    <= state_nxt;
      cur_code <= code_nxt;
      run_len  <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = cur_code;
    len_nxt   = run_len;
    push      = 1'b0;
    push_rec  = {cur_code, run_len};
    case (state)
      IDLE: begin
        if (!bus.flush) begin
          state_nxt = RUN;
          code_nxt  = samp_code;
          len_nxt   = LEN_W'(1);
        end
      end
      RUN: begin
        if (bus.flush) begin
          push      = 1'b1;
          state_nxt = IDLE;
          code_nxt  = 4'd0;
          len_nxt   = '0;
        end else if (samp_code != cur_code || run_len == LEN_MAX) begin
          // A saturated run is split so the length field never wraps.
          push     = 1'b1;
          code_nxt = samp_code;
          len_nxt  = LEN_W'(1);
        end else begin
          len_nxt = run_len + LEN_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign full   = (count == CW'(DEPTH));
  assign pop    = bus.rec_valid && bus.rec_ready;
  assign accept = push && (!full || pop);

  // When full, wr_ptr equals rd_ptr, so a push with pop reuses the slot being vacated.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= push_rec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (accept && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !accept) begin
        count <= count - CW'(1);
      end
    end
  end

  // Head fields are forced to zero whenever the FIFO is empty, including reset.
  assign head          = bus.rec_valid ? mem[rd_ptr] : '0;
  assign bus.rec_valid = (count != '0);
  assign bus.rec_err   = head[REC_W-1];
  assign bus.rec_idx   = head[REC_W-2 -: 3];
  assign bus.rec_len   = head[LEN_W-1:0];
  assign bus.fifo_full = full;

`ifdef DROP_COUNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 8'd0;
    end else if (push && full && !pop && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_onehot_run_encoder.sv
// tb/tb_onehot_run_encoder.sv - directed self-checking bench for onehot_run_encoder
// Run with and without DROP_COUNT_EN defined.
module tb_onehot_run_encoder;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  onehot_run_encoder_if #(.LEN_W(8)) bus ();

  onehot_run_encoder #(.DEPTH(4), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic v, input logic e,
                           input logic [2:0] i, input logic [7:0] l);
    check({tag, ".valid"}, 32'(bus.rec_valid), 32'(v));
    check({tag, ".err"},   32'(bus.rec_err),   32'(e));
    check({tag, ".idx"},   32'(bus.rec_idx),   32'(i));
    check({tag, ".len"},   32'(bus.rec_len),   32'(l));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_onehot = 8'h01;
    bus.flush     = 1'b0;
    bus.rec_ready = 1'b1;
    step(3);
    check_rec("reset", 1'b0, 1'b0, 3'd0, 8'd0);
    check("reset.full", 32'(bus.fifo_full), 32'd0);
`ifdef DROP_COUNT_EN
    check("reset.drop", 32'(bus.drop_cnt), 32'd0);
`endif

    // 0x01 for 5 cycles, then 0x04
    rst_n = 1'b1;
    step(5);
    check("s37.pre", 32'(bus.rec_valid), 32'd0);
    bus.in_onehot = 8'h04;
    step(1);
    check_rec("s37", 1'b1, 1'b0, 3'd0, 8'd5);

    bus.flush = 1'b1;
    step(1);
    check_rec("flush1", 1'b1, 1'b0, 3'd2, 8'd1);

    // illegal words 0x03 x3, 0x00 x2 form one run of 5
    bus.flush     = 1'b0;
    bus.in_onehot = 8'h03;
    step(1);
    check("s38.empty", 32'(bus.rec_valid), 32'd0);
    step(2);
    bus.in_onehot = 8'h00;
    step(2);
    bus.in_onehot = 8'h80;
    step(1);
    check_rec("s38", 1'b1, 1'b1, 3'd0, 8'd5);

    // 0x10 for 300 cycles splits into 255 + 45
    bus.in_onehot = 8'h10;
    step(1);
    check_rec("s39.r80", 1'b1, 1'b0, 3'd7, 8'd1);
    step(254);
    check("s39.nowrap", 32'(bus.rec_valid), 32'd0);
    step(1);
    check_rec("s39.sat", 1'b1, 1'b0, 3'd4, 8'd255);
    step(44);
    bus.flush = 1'b1;
    step(1);
    check_rec("s39.tail", 1'b1, 1'b0, 3'd4, 8'd45);
    step(2);
    check("s39.idleflush", 32'(bus.rec_valid), 32'd0);
    bus.flush     = 1'b0;
    bus.in_onehot = 8'h02;
    step(1);
    bus.flush = 1'b1;
    step(1);
    check_rec("s39.idle", 1'b1, 1'b0, 3'd1, 8'd1);

    // fill with ready low: four records kept, fifth dropped
    bus.flush     = 1'b0;
    bus.in_onehot = 8'h01;
    step(1);
    check("s40.empty", 32'(bus.rec_valid), 32'd0);
    bus.rec_ready = 1'b0;
    bus.in_onehot = 8'h02;
    step(1);
    bus.in_onehot = 8'h04;
    step(1);
    bus.in_onehot = 8'h08;
    step(1);
    check("s40.notfull", 32'(bus.fifo_full), 32'd0);
    bus.in_onehot = 8'h10;
    step(1);
    check("s40.full4", 32'(bus.fifo_full), 32'd1);
    bus.in_onehot = 8'h20;
    step(1);
    check("s40.full", 32'(bus.fifo_full), 32'd1);
    check_rec("s40.head", 1'b1, 1'b0, 3'd0, 8'd1);
`ifdef DROP_COUNT_EN
    check("s40.drop", 32'(bus.drop_cnt), 32'd1);
`endif
    step(1);
    check_rec("s40.stable", 1'b1, 1'b0, 3'd0, 8'd1);

    // full with pop and push on the same edge
    bus.rec_ready = 1'b1;
    bus.in_onehot = 8'h40;
    step(1);
    check("s41.full", 32'(bus.fifo_full), 32'd1);
    check("s41.head", 32'(bus.rec_idx), 32'd1);
`ifdef DROP_COUNT_EN
    check("s41.drop", 32'(bus.drop_cnt), 32'd1);
`endif
    step(1);
    check("s41.o2", 32'(bus.rec_idx), 32'd2);
    step(1);
    check("s41.o3", 32'(bus.rec_idx), 32'd3);
    step(1);
    check_rec("s41.o5", 1'b1, 1'b0, 3'd5, 8'd2);
    step(1);
    check("s41.drained", 32'(bus.rec_valid), 32'd0);
    check("s41.nfull", 32'(bus.fifo_full), 32'd0);

    // reset mid-run of 0x20 with two records queued
    bus.rec_ready = 1'b0;
    bus.in_onehot = 8'h10;
    step(1);
    bus.in_onehot = 8'h20;
    step(2);
    check_rec("s42.pre", 1'b1, 1'b0, 3'd6, 8'd5);
    rst_n = 1'b0;
    #1;
    check_rec("s42.async", 1'b0, 1'b0, 3'd0, 8'd0);
    check("s42.full", 32'(bus.fifo_full), 32'd0);
`ifdef DROP_COUNT_EN
    check("s42.drop", 32'(bus.drop_cnt), 32'd0);
`endif
    step(2);
    check("s42.held", 32'(bus.rec_valid), 32'd0);
    rst_n         = 1'b1;
    bus.rec_ready = 1'b1;
    step(3);
    check("s42.none", 32'(bus.rec_valid), 32'd0);
    bus.flush = 1'b1;
    step(1);
    check_rec("s42.fresh", 1'b1, 1'b0, 3'd5, 8'd3);

`ifdef DROP_COUNT_EN
    // many drops saturate the counter
    bus.flush     = 1'b0;
    bus.rec_ready = 1'b0;
    for (int k = 0; k < 270; k++) begin
      bus.in_onehot = (k % 2 == 0) ? 8'h01 : 8'h02;
      step(1);
    end
    check("sat.drop", 32'(bus.drop_cnt), 32'd255);
    check("sat.head", 32'(bus.rec_idx), 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/onehot_run_encoder.md
ONEHOT_RUN_ENCODER -- requirements
Module: onehot_run_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the record FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have parameter LEN_W, default 8, giving the run-length field width.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_onehot, input, 8, the one-hot state word from the upstream gray-coded controller, sampled every cycle.
REQ-006 Port flush, input, 1, a request to close the current run.
REQ-007 Port rec_valid, output, 1, high when the FIFO holds at least one record.
REQ-008 Port rec_ready, input, 1, consumer accept; a pop occurs when rec_valid and rec_ready are both high.
REQ-009 Port rec_idx, output, 3, the encoded index of the head record.
REQ-010 Port rec_err, output, 1, high when the head record is an illegal-code run.
REQ-011 Port rec_len, output, LEN_W, the run length of the head record, in cycles.
REQ-012 Port fifo_full, output, 1, high when the FIFO holds DEPTH records.
REQ-013 Port drop_cnt, output, 8, the dropped-record count; it exists only under DROP_COUNT_EN.

Function
REQ-014 Encoding: a word with exactly one bit set SHALL map to code {err=0, idx=bit position}.
REQ-015 Encoding: a word with zero bits or more than one bit set SHALL map to code {err=1, idx=0}, and all illegal words SHALL be treated as one code.
REQ-016 The FSM SHALL have two states: IDLE (no open run) and RUN (open run holding cur_code and run_len).
REQ-017 In IDLE with flush low, the sample SHALL open a run with cur_code set to the sample code and run_len=1, and the FSM SHALL go to RUN.
REQ-018 In RUN with flush low, when the sample code equals cur_code and run_len < 2^LEN_W-1, run_len SHALL increment.
REQ-019 In RUN with flush low, when the sample code differs from cur_code, the block SHALL push {cur_code, run_len} and open a new run with the sample code and run_len=1.
REQ-020 In RUN with flush low, when the sample code is the same and run_len = 2^LEN_W-1, the block SHALL push the saturated record and open a new run with run_len=1, so that runs are split and never wrap.
REQ-021 With flush high, the in_onehot sample SHALL be ignored, an open run SHALL be pushed, and the FSM SHALL go to IDLE.
REQ-022 Flush in IDLE SHALL have no effect.
REQ-023 Latency: a pushed record SHALL be visible on the rec_* outputs immediately after the edge that closes the run, when the FIFO was empty.
REQ-024 Records SHALL be delivered in push order.
REQ-025 The rec_* outputs SHALL be stable while rec_valid is high and rec_ready is low.
REQ-026 A push while the FIFO is full and no pop occurs on the same edge SHALL be dropped, and the FIFO contents SHALL be unchanged.
REQ-027 A simultaneous push and pop when the FIFO is full SHALL accept the push, and the occupancy SHALL remain DEPTH.
REQ-028 A simultaneous push and pop at any other occupancy SHALL leave the occupancy unchanged.
REQ-029 A pop when the FIFO is empty SHALL be impossible, since rec_valid is low.
REQ-030 At most one push SHALL occur per cycle.

Reset
REQ-031 While rst_n is low, the FSM SHALL be in IDLE, run_len and cur_code SHALL be 0, and the FIFO SHALL be empty.
REQ-032 While rst_n is low, rec_valid, rec_idx, rec_err, rec_len and fifo_full SHALL all be 0, and drop_cnt SHALL be 0 when present.
REQ-033 Reset asserted mid-run SHALL discard the open run and all queued records, with no push.
REQ-034 The first rising edge after rst_n deasserts SHALL be treated as an IDLE sample.

Configuration
REQ-035 With DROP_COUNT_EN defined, drop_cnt SHALL increment by 1 for each dropped push and SHALL saturate at 255.
REQ-036 With DROP_COUNT_EN undefined, the drop_cnt port and its counter SHALL be absent, and drops SHALL be silent.

Verification
REQ-037 Scenario: reset, then hold in_onehot=0x01 for 5 cycles, then 0x04 -> one record {idx=0, err=0, len=5} appears after the 0x04 edge.
REQ-038 Scenario: in_onehot=0x03 for 3 cycles, then 0x00 for 2 cycles, then 0x80 -> one record {err=1, idx=0, len=5}.
REQ-039 Scenario: hold 0x10 for 300 cycles, then flush -> records {idx=4, len=255} and {idx=4, len=45}, then the FSM is in IDLE.
REQ-040 Scenario: rec_ready low, DEPTH=4, with 6 code changes -> fifo_full=1, the first 4 records are kept in order, and drop_cnt=1 (under DROP_COUNT_EN).
REQ-041 Scenario: FIFO full, rec_ready high, and a code change on the same edge -> the push is accepted, the occupancy stays 4, and drop_cnt is unchanged.
REQ-042 Scenario: rst_n pulled low during a run of 0x20 with 2 records queued -> all outputs read 0 and no record emerges after release.
